button_conditioner: RTL and testbench

// - Conditions one raw push-button pin for the clock-setting logic (one instance per button).
// - Synchronises the pin to clk, debounces it, and produces a clean level BTN.
// - Also produces single-cycle press/release pulses BTN_pos/BTN_neg that feed a smart_counter's BTN, BTN_pos and BTN_neg inputs.

---
 rtl/button_conditioner.sv | 100 ++++++++++
 tb/tb_button_conditioner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, registered level and edge pulses.
// Build option BTN_ACTIVE_LOW_EN: pin is active-low (pull-up button), inverted at the synchroniser input.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN_raw,
  output logic BTN,
  output logic BTN_pos,
  output logic BTN_neg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  logic                   pin_lvl;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;

  // Flops always hold the pressed-level, so a cleared chain means "not pressed" in both builds.
`ifdef BTN_ACTIVE_LOW_EN
  assign pin_lvl = ~BTN_raw;
`else
  assign pin_lvl = BTN_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_lvl};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            btn_q, btn_d;
  logic            pos_q, pos_d;
  logic            neg_q, neg_d;

  // The entry cycle counts as the first qualifying sample, giving SYNC_STAGES+DEBOUNCE_CYCLES latency.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      RELEASED: begin
        if (btn_s) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!btn_s)                   state_d = RELEASED;
        else if (cnt_inc == CNT_LAST) state_d = PRESSED;
        else                          cnt_d   = cnt_inc;
      end
      PRESSED: begin
        if (!btn_s) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (btn_s)                    state_d = PRESSED;
        else if (cnt_inc == CNT_LAST) state_d = RELEASED;
        else                          cnt_d   = cnt_inc;
      end
      default: state_d = RELEASED;
    endcase
    btn_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    pos_d = btn_d & ~btn_q;
    neg_d = ~btn_d & btn_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign BTN     = btn_q;
  assign BTN_pos = pos_q;
  assign BTN_neg = neg_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2 (latency 10 posedges).
module tb_button_conditioner;

`ifdef BTN_ACTIVE_LOW_EN
  localparam logic PR = 1'b0;
`else
  localparam logic PR = 1'b1;
`endif
  localparam logic RL = ~PR;

  logic clk, rst, BTN_raw;
  logic BTN, BTN_pos, BTN_neg;

  int n_tests = 0;
  int n_fail  = 0;
  int pos_cnt = 0;
  int neg_cnt = 0;
  int pulse_bad = 0;
  logic prev_pulse = 1'b0;

  button_conditioner #(.DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .BTN_raw(BTN_raw),
    .BTN(BTN), .BTN_pos(BTN_pos), .BTN_neg(BTN_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      pos_cnt += int'(BTN_pos);
      neg_cnt += int'(BTN_neg);
      if ((BTN_pos && BTN_neg) || (prev_pulse && (BTN_pos || BTN_neg))) pulse_bad++;
      prev_pulse = BTN_pos | BTN_neg;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    BTN_raw = RL;
    // Reset with a toggling pin: outputs held low.
    #2;
    chk("rst_btn", int'(BTN), 0);
    for (int i = 0; i < 6; i++) begin
      BTN_raw = ~BTN_raw;
      #7;
    end
    chk("rst_btn_tog", int'(BTN), 0);
    chk("rst_pos", int'(BTN_pos), 0);
    chk("rst_neg", int'(BTN_neg), 0);
    BTN_raw = RL;
    step(2);
    rst = 1'b1;
    step(3);
    chk("idle_btn", int'(BTN), 0);

    // Clean press held 20 cycles.
    BTN_raw = PR;
    step(9);
    chk("press_early", int'(BTN), 0);
    step(1);
    chk("press_btn", int'(BTN), 1);
    chk("press_pos", int'(BTN_pos), 1);
    chk("press_neg", int'(BTN_neg), 0);
    step(1);
    chk("press_pos_once", int'(BTN_pos), 0);
    chk("press_hold", int'(BTN), 1);
    step(9);

    // Release with a 4-cycle high glitch.
    BTN_raw = RL;
    step(3);
    BTN_raw = PR;
    step(4);
    chk("glitch_hold", int'(BTN), 1);
    BTN_raw = RL;
    step(9);
    chk("rel_early", int'(BTN), 1);
    chk("rel_no_neg", neg_cnt, 0);
    step(1);
    chk("rel_btn", int'(BTN), 0);
    chk("rel_neg", int'(BTN_neg), 1);
    step(1);
    chk("rel_neg_once", int'(BTN_neg), 0);
    chk("pair_pos", pos_cnt, 1);
    chk("pair_neg", neg_cnt, 1);
    step(4);

    // Bounce: 5 high, 3 low, then 15 high.
    BTN_raw = PR;
    step(5);
    BTN_raw = RL;
    step(3);
    chk("bounce_no_pos", pos_cnt, 1);
    chk("bounce_btn", int'(BTN), 0);
    BTN_raw = PR;
    step(9);
    chk("bounce_early", int'(BTN), 0);
    step(1);
    chk("bounce_btn_up", int'(BTN), 1);
    chk("bounce_pos", int'(BTN_pos), 1);
    step(5);
    BTN_raw = RL;
    step(10);
    chk("bounce_rel", int'(BTN), 0);
    chk("bounce_neg", int'(BTN_neg), 1);
    step(4);

    // Reset mid-press, pin held through reset release.
    BTN_raw = PR;
    step(12);
    chk("mid_btn_pre", int'(BTN), 1);
    chk("mid_pos_cnt", pos_cnt, 3);
    rst = 1'b0;
    #1;
    chk("mid_btn_async", int'(BTN), 0);
    chk("mid_neg_async", int'(BTN_neg), 0);
    step(3);
    chk("mid_btn_inrst", int'(BTN), 0);
    rst = 1'b1;
    step(9);
    chk("mid_early", int'(BTN), 0);
    chk("mid_no_neg", neg_cnt, 2);
    step(1);
    chk("mid_btn_up", int'(BTN), 1);
    chk("mid_pos", int'(BTN_pos), 1);
    step(2);
    BTN_raw = RL;
    step(12);
    chk("final_btn", int'(BTN), 0);
    chk("final_pos_cnt", pos_cnt, 4);
    chk("final_neg_cnt", neg_cnt, 3);
    chk("pulse_rules", pulse_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
